// File: rtl/stopwatch_up.sv
// Up-counting MM:SS stopwatch: one-second prescaler, four-digit BCD chain,
// run/pause/idle control and a lap register that freezes the display.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cleared, counts zero, waiting for start_stop
// ST_RUN   | prescaler advancing, digits increment on each tick
// ST_PAUSE | prescaler and digits hold; start_stop resumes
module stopwatch_up #(
   parameter int TICK_DIV = 50_000_000,
   parameter bit SATURATE = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start_stop,
   input  logic        i_clear,
   input  logic        i_lap,
   output logic [15:0] o_digits,
   output logic        o_running,
   output logic        o_lapped,
   output logic        o_tick,
   output logic        o_wrap
);

   localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ps_q, ps_d;
   logic [3:0]    s0_q, s1_q, m0_q, m1_q;
   logic [3:0]    s0_d, s1_d, m0_d, m1_d;
   logic [15:0]   snap_q, snap_d;
   logic          lapped_q, lapped_d;
   logic          wrap_q, wrap_d;
   logic          run_st;
   logic          tick;
   logic          at_max;
   logic [15:0]   live;

   assign run_st = (state_q == ST_RUN);
   assign tick   = run_st && (ps_q == PS_LAST);
   assign live   = {m1_q, m0_q, s1_q, s0_q};
   assign at_max = (live == 16'h5959);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; clear wins over everything, a tick in the same cycle
   // as start_stop is still applied by the datapath before pausing.
   always_comb begin
      state_d = state_q;
      if (i_clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (i_start_stop) state_d = ST_RUN;
            ST_RUN: begin
               if (i_start_stop)                    state_d = ST_PAUSE;
               else if (tick && at_max && SATURATE) state_d = ST_PAUSE;
            end
            ST_PAUSE: if (i_start_stop) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // FSM-derived outputs.
   always_comb begin
      o_running = run_st;
      o_tick    = tick;
   end

   // Prescaler next value: advances only in RUN, holds partial seconds in PAUSE.
   always_comb begin
      ps_d = ps_q;
      if (i_clear)     ps_d = '0;
      else if (tick)   ps_d = '0;
      else if (run_st) ps_d = ps_q + 1'b1;
   end

   // BCD digit chain with ripple carry; saturating mode holds at 59:59.
   always_comb begin
      s0_d = s0_q;
      s1_d = s1_q;
      m0_d = m0_q;
      m1_d = m1_q;
      if (i_clear) begin
         s0_d = 4'd0;
         s1_d = 4'd0;
         m0_d = 4'd0;
         m1_d = 4'd0;
      end else if (tick && !(at_max && SATURATE)) begin
         if (s0_q != 4'd9) begin
            s0_d = s0_q + 4'd1;
         end else begin
            s0_d = 4'd0;
            if (s1_q != 4'd5) begin
               s1_d = s1_q + 4'd1;
            end else begin
               s1_d = 4'd0;
               if (m0_q != 4'd9) begin
                  m0_d = m0_q + 4'd1;
               end else begin
                  m0_d = 4'd0;
                  if (m1_q != 4'd5) m1_d = m1_q + 4'd1;
                  else              m1_d = 4'd0;
               end
            end
         end
      end
   end

   // Lap snapshot: capture pre-increment live value in RUN, release anywhere.
   always_comb begin
      snap_d   = snap_q;
      lapped_d = lapped_q;
      if (i_clear) begin
         snap_d   = 16'h0000;
         lapped_d = 1'b0;
      end else if (i_lap && lapped_q) begin
         lapped_d = 1'b0;
      end else if (i_lap && run_st) begin
         snap_d   = live;
         lapped_d = 1'b1;
      end
   end

   // Terminal-count pulse, registered so it lands the cycle after 59:59 ticks.
   always_comb begin
      wrap_d = !i_clear && tick && at_max;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q     <= '0;
         s0_q     <= 4'd0;
         s1_q     <= 4'd0;
         m0_q     <= 4'd0;
         m1_q     <= 4'd0;
         snap_q   <= 16'h0000;
         lapped_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         ps_q     <= ps_d;
         s0_q     <= s0_d;
         s1_q     <= s1_d;
         m0_q     <= m0_d;
         m1_q     <= m1_d;
         snap_q   <= snap_d;
         lapped_q <= lapped_d;
         wrap_q   <= wrap_d;
      end
   end

   assign o_digits = lapped_q ? snap_q : live;
   assign o_lapped = lapped_q;
   assign o_wrap   = wrap_q;

endmodule

// File: tb/tb_stopwatch_up.sv
// Bench for stopwatch_up: a wrapping and a saturating instance share stimulus.
module tb_stopwatch_up;

   logic        clk;
   logic        rst_n;
   logic        start, clr, lap;
   logic [15:0] dig0, dig1;
   logic        run0, lap0, tick0, wrap0;
   logic        run1, lap1, tick1, wrap1;

   int checks = 0;
   int errors = 0;

   stopwatch_up #(.TICK_DIV(4), .SATURATE(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .i_start_stop(start), .i_clear(clr), .i_lap(lap),
      .o_digits(dig0), .o_running(run0), .o_lapped(lap0), .o_tick(tick0), .o_wrap(wrap0)
   );

   stopwatch_up #(.TICK_DIV(4), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .i_start_stop(start), .i_clear(clr), .i_lap(lap),
      .o_digits(dig1), .o_running(run1), .o_lapped(lap1), .o_tick(tick1), .o_wrap(wrap1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start, clear, lap;
      logic [15:0] digits;
      logic        run, lapd, tick, wrap;
   } vec_t;

   vec_t vecs[32];

   function automatic vec_t mk(input logic s, input logic c, input logic l,
                               input logic [15:0] d, input logic r, input logic ld,
                               input logic t, input logic w);
      vec_t v;
      v.start = s; v.clear = c; v.lap = l; v.digits = d;
      v.run = r; v.lapd = ld; v.tick = t; v.wrap = w;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pulse_clear();
      clr = 1'b1; step(); clr = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1; step(); lap = 1'b0;
   endtask

   task automatic run_until(input logic [15:0] target, input int budget, input string nm);
      int n = 0;
      while (dig0 !== target && n < budget) begin
         step();
         n++;
      end
      chk(nm, dig0, target);
   endtask

   task automatic wait_tick(input int budget, input string nm);
      int n = 0;
      while (tick0 !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk(nm, tick0, 1'b1);
   endtask

   initial begin
      // start clear lap | digits run lapped tick wrap
      vecs[0]  = mk(1,0,0, 16'h0000, 0,0,0,0);
      vecs[1]  = mk(0,0,0, 16'h0000, 1,0,0,0);
      vecs[2]  = mk(0,0,0, 16'h0000, 1,0,0,0);
      vecs[3]  = mk(0,0,0, 16'h0000, 1,0,0,0);
      vecs[4]  = mk(0,0,0, 16'h0000, 1,0,1,0);
      vecs[5]  = mk(0,0,0, 16'h0001, 1,0,0,0);
      vecs[6]  = mk(0,0,0, 16'h0001, 1,0,0,0);
      vecs[7]  = mk(0,0,0, 16'h0001, 1,0,0,0);
      vecs[8]  = mk(0,0,0, 16'h0001, 1,0,1,0);
      vecs[9]  = mk(0,0,0, 16'h0002, 1,0,0,0);
      vecs[10] = mk(0,0,0, 16'h0002, 1,0,0,0);
      vecs[11] = mk(0,0,0, 16'h0002, 1,0,0,0);
      vecs[12] = mk(0,0,0, 16'h0002, 1,0,1,0);
      vecs[13] = mk(0,0,0, 16'h0003, 1,0,0,0);
      vecs[14] = mk(1,0,0, 16'h0003, 1,0,0,0);
      vecs[15] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[16] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[17] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[18] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[19] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[20] = mk(0,0,1, 16'h0003, 0,0,0,0);
      vecs[21] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[22] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[23] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[24] = mk(0,0,0, 16'h0003, 0,0,0,0);
      vecs[25] = mk(1,0,0, 16'h0003, 0,0,0,0);
      vecs[26] = mk(0,0,0, 16'h0003, 1,0,0,0);
      vecs[27] = mk(1,0,0, 16'h0003, 1,0,1,0);
      vecs[28] = mk(0,0,0, 16'h0004, 0,0,0,0);
      vecs[29] = mk(0,0,0, 16'h0004, 0,0,0,0);
      vecs[30] = mk(0,1,0, 16'h0004, 0,0,0,0);
      vecs[31] = mk(0,0,0, 16'h0000, 0,0,0,0);

      rst_n = 1'b0;
      start = 1'b0; clr = 1'b0; lap = 1'b0;
      step();
      step();
      chk("reset_digits", dig0, 16'h0000);
      chk("reset_running", run0, 1'b0);
      rst_n = 1'b1;
      chk("post_reset_lapped", lap0, 1'b0);
      chk("post_reset_tick", tick0, 1'b0);
      chk("post_reset_wrap", wrap0, 1'b0);

      // Basic counting, pause/resume, lap ignored in PAUSE, tick+pause, clear.
      for (int i = 0; i < 32; i++) begin
         start = vecs[i].start;
         clr   = vecs[i].clear;
         lap   = vecs[i].lap;
         chk($sformatf("v%0d_digits", i),  dig0,  vecs[i].digits);
         chk($sformatf("v%0d_running", i), run0,  vecs[i].run);
         chk($sformatf("v%0d_lapped", i),  lap0,  vecs[i].lapd);
         chk($sformatf("v%0d_tick", i),    tick0, vecs[i].tick);
         chk($sformatf("v%0d_wrap", i),    wrap0, vecs[i].wrap);
         step();
      end
      start = 1'b0; clr = 1'b0; lap = 1'b0;

      // Lap freeze at 00:12 while live advances to 00:15.
      pulse_start();
      run_until(16'h0012, 100, "reach_0012");
      pulse_lap();
      chk("lap_set_flag", lap0, 1'b1);
      chk("lap_set_digits", dig0, 16'h0012);
      begin
         int nt = 0;
         int bad = 0;
         for (int k = 0; k < 40 && nt < 3; k++) begin
            if (tick0 === 1'b1) nt++;
            if (dig0 !== 16'h0012 || lap0 !== 1'b1) bad++;
            step();
         end
         chk("lap_held_cycles_bad", bad, 0);
         chk("lap_ticks_seen", nt, 3);
      end
      pulse_lap();
      chk("lap_release_digits", dig0, 16'h0015);
      chk("lap_release_flag", lap0, 1'b0);

      // Carry chain and terminal count for both SATURATE settings.
      pulse_clear();
      chk("clear_digits", dig0, 16'h0000);
      pulse_start();
      run_until(16'h0959, 3000, "reach_0959");
      wait_tick(8, "tick_at_0959");
      step();
      chk("carry_1000", dig0, 16'h1000);
      run_until(16'h5959, 16000, "reach_5959");
      chk("sat_reach_5959", dig1, 16'h5959);
      wait_tick(8, "tick_at_5959");
      chk("wrap_before", wrap0, 1'b0);
      step();
      chk("wrap0_digits", dig0, 16'h0000);
      chk("wrap0_running", run0, 1'b1);
      chk("wrap0_pulse", wrap0, 1'b1);
      chk("sat_digits", dig1, 16'h5959);
      chk("sat_running", run1, 1'b0);
      chk("sat_pulse", wrap1, 1'b1);
      step();
      chk("wrap0_pulse_end", wrap0, 1'b0);
      chk("sat_pulse_end", wrap1, 1'b0);
      chk("sat_hold", dig1, 16'h5959);
      pulse_start();
      chk("sat_resumed", run1, 1'b1);
      begin
         int n = 0;
         while (tick1 !== 1'b1 && n < 8) begin
            step();
            n++;
         end
         chk("sat_resume_tick", tick1, 1'b1);
         chk("sat_resume_tick_latency", n, 3);
      end
      step();
      chk("sat_rewrap_pulse", wrap1, 1'b1);
      chk("sat_rewrap_digits", dig1, 16'h5959);
      chk("sat_rewrap_running", run1, 1'b0);

      // Clear together with start_stop, lap and tick.
      pulse_clear();
      pulse_start();
      pulse_lap();
      chk("pre_clear_lapped", lap0, 1'b1);
      wait_tick(8, "tick_for_clear");
      start = 1'b1; clr = 1'b1; lap = 1'b1;
      step();
      start = 1'b0; clr = 1'b0; lap = 1'b0;
      chk("clr_digits", dig0, 16'h0000);
      chk("clr_lapped", lap0, 1'b0);
      chk("clr_running", run0, 1'b0);
      chk("clr_tick", tick0, 1'b0);
      step();
      chk("clr_stays_idle", run0, 1'b0);

      // Asynchronous reset at 00:37 with the display frozen.
      pulse_start();
      run_until(16'h0037, 300, "reach_0037");
      pulse_lap();
      chk("pre_rst_lapped", lap0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_digits", dig0, 16'h0000);
      chk("arst_lapped", lap0, 1'b0);
      chk("arst_running", run0, 1'b0);
      chk("arst_tick", tick0, 1'b0);
      chk("arst_wrap", wrap0, 1'b0);
      step();
      rst_n = 1'b1;
      pulse_start();
      chk("restart_digits", dig0, 16'h0000);
      wait_tick(8, "restart_tick");
      step();
      chk("restart_0001", dig0, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_up.md
Name: stopwatch_up

Overview:
- Up-counting MM:SS stopwatch; the count-up counterpart of the team's countdown timer.
- Contains a clock prescaler, a four-digit BCD up-counter chain with carry, a run/pause/idle control FSM and a lap-freeze display register.
- Sits between debounced button pulses and the 7-segment digit mux; o_digits feeds the mux directly.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per one-second tick; legal range >= 2. Benches use 4.
- SATURATE, 0: 0 = wrap 59:59 -> 00:00 and keep running; 1 = hold 59:59 and go to PAUSE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start_stop  in  1  single-cycle pulse; starts, pauses or resumes counting.
- i_clear  in  1  single-cycle pulse; returns the block to IDLE with all counts zero.
- i_lap  in  1  single-cycle pulse; freezes or releases the displayed value.
- o_digits  out  16  displayed BCD value {m1,m0,s1,s0}, one nibble per digit, m1 in bits [15:12].
- o_running  out  1  high while FSM is in RUN.
- o_lapped  out  1  high while the display is frozen.
- o_tick  out  1  combinational; high in the cycle a one-second increment is applied.
- o_wrap  out  1  registered single-cycle pulse, the cycle after 59:59 is reached by a tick.

Behaviour:
- Reset (async): FSM = IDLE; prescaler = 0; live digits = 0; snapshot = 0; lapped = 0; o_wrap = 0. Outputs read o_digits = 16'h0000, o_running = 0, o_lapped = 0, o_tick = 0.
- Prescaler:
  - Width is $clog2(TICK_DIV).
  - Increments only in RUN.
  - At TICK_DIV-1 it wraps to 0 and o_tick = 1 (o_tick = RUN && prescaler == TICK_DIV-1).
  - Holds its value in PAUSE, so a partial second is preserved.
  - Zeroed on clear.
- Digit chain, updated on the edge ending an o_tick cycle and visible the next cycle:
  - s0 counts 0..9; at 9 it wraps to 0 and carries.
  - s1 counts 0..5 and advances only on the s0 carry.
  - m0 counts 0..9 and advances on the s1 carry.
  - m1 counts 0..5 and advances on the m0 carry.
  - Digits never hold non-BCD values or s1/m1 > 5.
- Terminal count 59:59 with a tick:
  - SATURATE = 0: digits become 00:00, FSM stays in RUN, o_wrap pulses the next cycle.
  - SATURATE = 1: digits hold 59:59, FSM goes to PAUSE, o_wrap pulses the next cycle. A later start_stop resumes, and the next tick re-asserts o_wrap with no digit change.
- FSM transitions, evaluated each cycle:
  - i_clear in any state: go to IDLE; zero the digits, prescaler and snapshot; lapped = 0. Clear has priority over start_stop, lap and tick in the same cycle.
  - IDLE + start_stop: go to RUN. The first tick comes TICK_DIV cycles after entry.
  - RUN + start_stop: go to PAUSE.
  - PAUSE + start_stop: go to RUN.
- Tick and start_stop in the same RUN cycle: the tick increment is applied, then the FSM pauses.
- Lap:
  - When lapped = 0 and state = RUN, i_lap copies the current live digits (the pre-increment value if a tick occurs in the same cycle) into the snapshot and sets lapped = 1.
  - When lapped = 1, i_lap clears lapped in any state.
  - i_lap with lapped = 0 in IDLE or PAUSE is ignored.
  - Live counting continues while lapped.
- o_digits = lapped ? snapshot : live digits. This is a pure mux of registers, with no added latency.
- start_stop and lap in the same cycle act independently.

Test Plan:
1. TICK_DIV = 4: reset; start_stop at cycle 0 -> o_tick high at cycles 4, 8, 12; o_digits = 0001, 0002, 0003 at cycles 5, 9, 13; o_running = 1.
2. Pause/resume: start; pause 2 cycles after a tick for 10 cycles; resume -> next tick 2 cycles after resume; no digit change while paused.
3. Carry chain: run to 09:59 -> next tick gives 10:00. Run to 59:59 with SATURATE = 0 -> 00:00 and o_wrap one cycle high. With SATURATE = 1 -> holds 59:59, o_running = 0, o_wrap pulses once.
4. Lap: at live 0012 assert i_lap -> o_digits stays 0012, o_lapped = 1 while live reaches 0015. i_lap again -> o_digits = 0015 next cycle, o_lapped = 0.
5. Simultaneous events:
   - i_clear with start_stop, lap and tick in one cycle -> next cycle IDLE, o_digits = 0000, o_lapped = 0, o_running = 0.
   - Tick with start_stop -> digit increments and o_running = 0.
6. Async reset mid-count at 00:37 with lapped = 1 -> all outputs zero immediately, before the next clk edge; after release, start restarts from 0000.
